// File: rtl/instr_trace_buf_pkg.sv
// Shared MIPS opcode constants and trace state encodings.
// Used by instr_trace_buf and instr_mnem_dec.
package instr_trace_buf_pkg;

  localparam logic [5:0] op_rtype  = 6'b000000;
  localparam logic [5:0] op_regimm = 6'b000001;
  localparam logic [5:0] op_j      = 6'b000010;
  localparam logic [5:0] op_jal    = 6'b000011;
  localparam logic [5:0] op_beq    = 6'b000100;
  localparam logic [5:0] op_bne    = 6'b000101;
  localparam logic [5:0] op_blez   = 6'b000110;
  localparam logic [5:0] op_bgtz   = 6'b000111;
  localparam logic [5:0] op_addi   = 6'b001000;
  localparam logic [5:0] op_addiu  = 6'b001001;
  localparam logic [5:0] op_slti   = 6'b001010;
  localparam logic [5:0] op_sltiu  = 6'b001011;
  localparam logic [5:0] op_andi   = 6'b001100;
  localparam logic [5:0] op_ori    = 6'b001101;
  localparam logic [5:0] op_xori   = 6'b001110;
  localparam logic [5:0] op_lui    = 6'b001111;
  localparam logic [5:0] op_cop0   = 6'b010000;
  localparam logic [5:0] op_lb     = 6'b100000;
  localparam logic [5:0] op_lh     = 6'b100001;
  localparam logic [5:0] op_lw     = 6'b100011;
  localparam logic [5:0] op_lbu    = 6'b100100;
  localparam logic [5:0] op_lhu    = 6'b100101;
  localparam logic [5:0] op_sb     = 6'b101000;
  localparam logic [5:0] op_sh     = 6'b101001;
  localparam logic [5:0] op_sw     = 6'b101011;

  localparam logic [5:0] funct_sll     = 6'b000000;
  localparam logic [5:0] funct_srl     = 6'b000010;
  localparam logic [5:0] funct_sra     = 6'b000011;
  localparam logic [5:0] funct_sllv    = 6'b000100;
  localparam logic [5:0] funct_srlv    = 6'b000110;
  localparam logic [5:0] funct_srav    = 6'b000111;
  localparam logic [5:0] funct_jr      = 6'b001000;
  localparam logic [5:0] funct_jalr    = 6'b001001;
  localparam logic [5:0] funct_syscall = 6'b001100;
  localparam logic [5:0] funct_break   = 6'b001101;
  localparam logic [5:0] funct_mfhi    = 6'b010000;
  localparam logic [5:0] funct_mthi    = 6'b010001;
  localparam logic [5:0] funct_mflo    = 6'b010010;
  localparam logic [5:0] funct_mtlo    = 6'b010011;
  localparam logic [5:0] funct_mult    = 6'b011000;
  localparam logic [5:0] funct_multu   = 6'b011001;
  localparam logic [5:0] funct_div     = 6'b011010;
  localparam logic [5:0] funct_divu    = 6'b011011;
  localparam logic [5:0] funct_add     = 6'b100000;
  localparam logic [5:0] funct_addu    = 6'b100001;
  localparam logic [5:0] funct_sub     = 6'b100010;
  localparam logic [5:0] funct_subu    = 6'b100011;
  localparam logic [5:0] funct_and     = 6'b100100;
  localparam logic [5:0] funct_or      = 6'b100101;
  localparam logic [5:0] funct_xor     = 6'b100110;
  localparam logic [5:0] funct_nor     = 6'b100111;
  localparam logic [5:0] funct_slt     = 6'b101010;
  localparam logic [5:0] funct_sltu    = 6'b101011;

  localparam logic [4:0] rt_bgez   = 5'b00001;
  localparam logic [4:0] rt_bgezal = 5'b10001;
  localparam logic [4:0] rt_bltz   = 5'b00000;
  localparam logic [4:0] rt_bltzal = 5'b10000;

  localparam logic [4:0] rs_mfc0 = 5'b00000;
  localparam logic [4:0] rs_mtc0 = 5'b00100;

  localparam logic [31:0] ERET_WORD = 32'h42000018;

  typedef enum logic [1:0] {
    TS_IDLE   = 2'd0,
    TS_ARMED  = 2'd1,
    TS_POST   = 2'd2,
    TS_FROZEN = 2'd3
  } trace_state_t;

endpackage

// File: rtl/instr_mnem_dec.sv
// Combinational MIPS instruction to ASCII mnemonic decoder.
// Names right-aligned; longer names keep rightmost CHARS chars.
module instr_mnem_dec
  import instr_trace_buf_pkg::*;
#(
  parameter int CHARS = 6
) (
  input  logic [31:0]        i_instr,
  output logic [8*CHARS-1:0] o_ascii
);

  localparam int W = 8 * CHARS;

  logic [5:0]  w_op;
  logic [5:0]  w_fn;
  logic [4:0]  w_rs;
  logic [4:0]  w_rt;
  logic [63:0] w_name;

  assign w_op = i_instr[31:26];
  assign w_rs = i_instr[25:21];
  assign w_rt = i_instr[20:16];
  assign w_fn = i_instr[5:0];

  // decode to an up-to-8-character name
  always_comb begin
    w_name = "N-R";
    case (w_op)
      op_rtype: begin
        case (w_fn)
          funct_sll:     w_name = "SLL";
          funct_srl:     w_name = "SRL";
          funct_sra:     w_name = "SRA";
          funct_sllv:    w_name = "SLLV";
          funct_srlv:    w_name = "SRLV";
          funct_srav:    w_name = "SRAV";
          funct_jr:      w_name = "JR";
          funct_jalr:    w_name = "JALR";
          funct_syscall: w_name = "SYSCALL";
          funct_break:   w_name = "BREAK";
          funct_mfhi:    w_name = "MFHI";
          funct_mthi:    w_name = "MTHI";
          funct_mflo:    w_name = "MFLO";
          funct_mtlo:    w_name = "MTLO";
          funct_mult:    w_name = "MULT";
          funct_multu:   w_name = "MULTU";
          funct_div:     w_name = "DIV";
          funct_divu:    w_name = "DIVU";
          funct_add:     w_name = "ADD";
          funct_addu:    w_name = "ADDU";
          funct_sub:     w_name = "SUB";
          funct_subu:    w_name = "SUBU";
          funct_and:     w_name = "AND";
          funct_or:      w_name = "OR";
          funct_xor:     w_name = "XOR";
          funct_nor:     w_name = "NOR";
          funct_slt:     w_name = "SLT";
          funct_sltu:    w_name = "SLTU";
          default:       w_name = "N-R";
        endcase
      end
      op_regimm: begin
        case (w_rt)
          rt_bgez:   w_name = "BGEZ";
          rt_bgezal: w_name = "BGEZAL";
          rt_bltz:   w_name = "BLTZ";
          rt_bltzal: w_name = "BLTZAL";
          default:   w_name = "N-R";
        endcase
      end
      op_cop0: begin
        if (i_instr == ERET_WORD)
          w_name = "ERET";
        else if (w_rs == rs_mfc0)
          w_name = "MFC0";
        else if (w_rs == rs_mtc0)
          w_name = "MTC0";
        else
          w_name = "N-R";
      end
      op_j:     w_name = "J";
      op_jal:   w_name = "JAL";
      op_beq:   w_name = "BEQ";
      op_bne:   w_name = "BNE";
      op_blez:  w_name = "BLEZ";
      op_bgtz:  w_name = "BGTZ";
      op_addi:  w_name = "ADDI";
      op_addiu: w_name = "ADDIU";
      op_slti:  w_name = "SLTI";
      op_sltiu: w_name = "SLTIU";
      op_andi:  w_name = "ANDI";
      op_ori:   w_name = "ORI";
      op_xori:  w_name = "XORI";
      op_lui:   w_name = "LUI";
      op_lb:    w_name = "LB";
      op_lh:    w_name = "LH";
      op_lw:    w_name = "LW";
      op_lbu:   w_name = "LBU";
      op_lhu:   w_name = "LHU";
      op_sb:    w_name = "SB";
      op_sh:    w_name = "SH";
      op_sw:    w_name = "SW";
      default:  w_name = "N-R";
    endcase
    if (i_instr == 32'd0)
      w_name = "NOP";
  end

  generate
    if (CHARS >= 8) begin : g_wide
      assign o_ascii = W'(w_name);
    end else begin : g_narrow
      assign o_ascii = w_name[W-1:0];
    end
  endgenerate

endmodule

// File: rtl/instr_trace_buf.sv
// Circular trace buffer of committed instructions with PC trigger.
// Optional macro TRACE_SKIP_NOP_EN drops instr==0 commits.
module instr_trace_buf
  import instr_trace_buf_pkg::*;
#(
  parameter int DEPTH    = 16,
  parameter int POST_CNT = 4,
  parameter int CHARS    = 6,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               commit_valid,
  input  logic [31:0]        commit_pc,
  input  logic [31:0]        commit_instr,
  input  logic               arm,
  input  logic               trig_en,
  input  logic [31:0]        trig_pc,
  input  logic [AW-1:0]      rd_idx,
  output logic               rd_valid,
  output logic [31:0]        rd_pc,
  output logic [31:0]        rd_instr,
  output logic [8*CHARS-1:0] rd_ascii,
  output logic [AW:0]        count,
  output logic [1:0]         state,
  output logic               triggered
);

  localparam logic [AW:0]   FULL  = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] PLOAD = AW'(POST_CNT);

  trace_state_t r_state, w_state_nxt;
  logic [AW-1:0] r_wr_ptr;
  logic [AW:0]   r_count;
  logic [AW-1:0] r_post, w_post_nxt;

  logic [31:0]        r_pc_mem    [DEPTH];
  logic [31:0]        r_instr_mem [DEPTH];
  logic [8*CHARS-1:0] r_ascii_mem [DEPTH];

  logic [8*CHARS-1:0] w_ascii;
  logic               w_keep;
  logic               w_cap;
  logic               w_hit;
  logic [AW-1:0]      w_waddr;
  logic [AW-1:0]      w_raddr;
  logic               w_rvalid;

  instr_mnem_dec #(.CHARS(CHARS)) u_dec (
    .i_instr (commit_instr),
    .o_ascii (w_ascii)
  );

`ifdef TRACE_SKIP_NOP_EN
  assign w_keep = (commit_instr != 32'd0);
`else
  assign w_keep = 1'b1;
`endif

  assign w_cap = commit_valid && w_keep &&
                 (arm || r_state == TS_ARMED ||
                  r_state == TS_POST);
  assign w_hit = commit_valid && trig_en &&
                 (commit_pc == trig_pc);
  assign w_waddr = arm ? '0 : r_wr_ptr;

  // trigger FSM next state and post counter
  always_comb begin
    w_state_nxt = r_state;
    w_post_nxt  = r_post;
    if (arm) begin
      w_state_nxt = TS_ARMED;
    end else begin
      case (r_state)
        TS_ARMED: begin
          if (w_hit) begin
            w_post_nxt  = PLOAD;
            w_state_nxt = (POST_CNT == 0) ? TS_FROZEN : TS_POST;
          end
        end
        TS_POST: begin
          if (w_cap) begin
            w_post_nxt = r_post - 1'b1;
            if (r_post == AW'(1))
              w_state_nxt = TS_FROZEN;
          end
        end
        default: ;
      endcase
    end
  end

  // state, write pointer, fill count
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= TS_IDLE;
      r_wr_ptr <= '0;
      r_count  <= '0;
      r_post   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_post  <= w_post_nxt;
      if (arm) begin
        r_wr_ptr <= w_cap ? AW'(1) : '0;
        r_count  <= w_cap ? (AW+1)'(1) : '0;
      end else if (w_cap) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
        if (r_count != FULL)
          r_count <= r_count + 1'b1;
      end
    end
  end

  // entry storage, not reset; validity comes from count
  always_ff @(posedge clk) begin
    if (w_cap) begin
      r_pc_mem[w_waddr]    <= commit_pc;
      r_instr_mem[w_waddr] <= commit_instr;
      r_ascii_mem[w_waddr] <= w_ascii;
    end
  end

  assign w_raddr  = r_wr_ptr - r_count[AW-1:0] + rd_idx;
  assign w_rvalid = ({1'b0, rd_idx} < r_count);

  // registered read port, zero data when out of range
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid <= 1'b0;
      rd_pc    <= '0;
      rd_instr <= '0;
      rd_ascii <= '0;
    end else begin
      rd_valid <= w_rvalid;
      rd_pc    <= w_rvalid ? r_pc_mem[w_raddr] : '0;
      rd_instr <= w_rvalid ? r_instr_mem[w_raddr] : '0;
      rd_ascii <= w_rvalid ? r_ascii_mem[w_raddr] : '0;
    end
  end

  assign count     = r_count;
  assign state     = r_state;
  assign triggered = (r_state == TS_POST) ||
                     (r_state == TS_FROZEN);

endmodule
